framed_packet_serializer: RTL and testbench

Parametrised successor to the fixed-size packet serializer in the BPSK chain. It accepts whole packets over a valid/ready handshake and emits a framed bit stream to the signal modulator. Each frame is a preamble, a sync word, the payload MSB-first, and an optional CRC-8 trailer. Bit advance is paced by the modulator's next-bit strobe, so the block sits between the packet source and `signal_modulator`.

---
 rtl/framed_packet_serializer.sv | 184 ++++++++++++++++++
 tb/tb_framed_packet_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/framed_packet_serializer.sv
// rtl/framed_packet_serializer.sv - framed bit-stream serializer: preamble, sync, payload, optional CRC-8
// Bit advance is paced by the downstream bit_next strobe; every output is registered.
module framed_packet_serializer #(
  parameter int          PACKET_SIZE   = 192,
  parameter int          PREAMBLE_BITS = 16,
  parameter int          SYNC_BITS     = 8,
  parameter logic [31:0] SYNC_WORD     = 32'h000000D3,
  parameter bit          CRC_EN        = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [PACKET_SIZE-1:0] pkt_data,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic                   bit_next,
  input  logic                   clear,
  output logic                   bit_out,
  output logic                   bit_active,
  output logic                   frame_done
);

  localparam int MAX_A   = (PREAMBLE_BITS > SYNC_BITS) ? PREAMBLE_BITS : SYNC_BITS;
  localparam int MAX_B   = (PACKET_SIZE > 8) ? PACKET_SIZE : 8;
  localparam int MAX_SEC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_SEC + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PACKET_SIZE - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(7);

  localparam logic [SYNC_BITS-1:0] SYNC_PAT  = SYNC_WORD[SYNC_BITS-1:0];
  localparam logic                 FIRST_BIT = (PREAMBLE_BITS > 0) ? 1'b1 : SYNC_PAT[SYNC_BITS-1];

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
    S_CRC
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [PACKET_SIZE-1:0] pay_q;
  logic [SYNC_BITS-1:0]   sync_q;
  logic [7:0]             crc_q;
  logic                   bit_out_q;
  logic                   bit_active_q;
  logic                   pkt_ready_q;
  logic                   frame_done_q;

  logic [PACKET_SIZE-1:0] pay_d;
  logic [SYNC_BITS-1:0]   sync_d;
  logic [7:0]             crc_d;
  logic [CNT_W-1:0]       cnt_d;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ (((c[7] ^ b) == 1'b1) ? 8'h07 : 8'h00);
  endfunction

  assign pay_d  = pay_q << 1;
  assign sync_d = sync_q << 1;
  assign crc_d  = crc_step(crc_q, pay_q[PACKET_SIZE-1]);
  assign cnt_d  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pay_q        <= '0;
      sync_q       <= '0;
      crc_q        <= '0;
      bit_out_q    <= 1'b0;
      bit_active_q <= 1'b0;
      pkt_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (clear) begin
        state_q      <= S_IDLE;
        cnt_q        <= '0;
        crc_q        <= '0;
        bit_out_q    <= 1'b0;
        bit_active_q <= 1'b0;
        pkt_ready_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (pkt_valid && pkt_ready_q) begin
              pay_q        <= pkt_data;
              sync_q       <= SYNC_PAT;
              crc_q        <= '0;
              cnt_q        <= '0;
              pkt_ready_q  <= 1'b0;
              bit_active_q <= 1'b1;
              bit_out_q    <= FIRST_BIT;
              state_q      <= (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_SYNC;
            end else begin
              pkt_ready_q <= 1'b1;
            end
          end
          S_PREAMBLE: begin
            if (bit_next) begin
              if (cnt_q == PRE_LAST) begin
                state_q   <= S_SYNC;
                cnt_q     <= '0;
                bit_out_q <= SYNC_PAT[SYNC_BITS-1];
              end else begin
                cnt_q     <= cnt_d;
                bit_out_q <= ~bit_out_q;
              end
            end
          end
          S_SYNC: begin
            if (bit_next) begin
              sync_q <= sync_d;
              if (cnt_q == SYNC_LAST) begin
                state_q   <= S_PAYLOAD;
                cnt_q     <= '0;
                bit_out_q <= pay_q[PACKET_SIZE-1];
              end else begin
                cnt_q     <= cnt_d;
                bit_out_q <= sync_d[SYNC_BITS-1];
              end
            end
          end
          S_PAYLOAD: begin
            // The CRC absorbs each payload bit as it is consumed, so it is final on the last one.
            if (bit_next) begin
              pay_q <= pay_d;
              crc_q <= crc_d;
              if (cnt_q == PAY_LAST) begin
                cnt_q <= '0;
                if (CRC_EN) begin
                  state_q   <= S_CRC;
                  bit_out_q <= crc_d[7];
                end else begin
                  state_q      <= S_IDLE;
                  bit_out_q    <= 1'b0;
                  bit_active_q <= 1'b0;
                  pkt_ready_q  <= 1'b1;
                  frame_done_q <= 1'b1;
                end
              end else begin
                cnt_q     <= cnt_d;
                bit_out_q <= pay_d[PACKET_SIZE-1];
              end
            end
          end
          S_CRC: begin
            if (bit_next) begin
              crc_q <= crc_q << 1;
              if (cnt_q == CRC_LAST) begin
                state_q      <= S_IDLE;
                cnt_q        <= '0;
                bit_out_q    <= 1'b0;
                bit_active_q <= 1'b0;
                pkt_ready_q  <= 1'b1;
                frame_done_q <= 1'b1;
              end else begin
                cnt_q     <= cnt_d;
                bit_out_q <= crc_q[6];
              end
            end
          end
          default: begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_out_q    <= 1'b0;
            bit_active_q <= 1'b0;
            pkt_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign pkt_ready  = pkt_ready_q;
  assign bit_out    = bit_out_q;
  assign bit_active = bit_active_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_framed_packet_serializer.sv
// tb/tb_framed_packet_serializer.sv - self-checking bench for framed_packet_serializer
// Two instances: full framing with CRC, and zero-preamble without CRC.
module tb_framed_packet_serializer;

  typedef bit bitq_t[$];

  localparam logic [71:0] MSG    = 72'h313233343536373839;
  localparam logic [7:0]  SYNC_W = 8'hD3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [71:0] pkt_data = '0;

  logic pkt_valid_a = 1'b0, bit_next_a = 1'b0, clear_a = 1'b0;
  logic pkt_ready_a, bit_out_a, bit_active_a, frame_done_a;
  logic pkt_valid_b = 1'b0, bit_next_b = 1'b0, clear_b = 1'b0;
  logic pkt_ready_b, bit_out_b, bit_active_b, frame_done_b;

  int          checks = 0;
  int          passes = 0;
  bitq_t       exp_a;
  bitq_t       exp_b;
  int          pos_a;
  logic [7:0]  cap_a;

  framed_packet_serializer #(
    .PACKET_SIZE(72), .PREAMBLE_BITS(4), .SYNC_BITS(8), .SYNC_WORD(32'h000000D3), .CRC_EN(1'b1)
  ) dut_a (
    .clk(clk), .rstn(rstn), .pkt_data(pkt_data), .pkt_valid(pkt_valid_a), .pkt_ready(pkt_ready_a),
    .bit_next(bit_next_a), .clear(clear_a), .bit_out(bit_out_a), .bit_active(bit_active_a),
    .frame_done(frame_done_a)
  );

  framed_packet_serializer #(
    .PACKET_SIZE(72), .PREAMBLE_BITS(0), .SYNC_BITS(8), .SYNC_WORD(32'h000000D3), .CRC_EN(1'b0)
  ) dut_b (
    .clk(clk), .rstn(rstn), .pkt_data(pkt_data), .pkt_valid(pkt_valid_b), .pkt_ready(pkt_ready_b),
    .bit_next(bit_next_b), .clear(clear_b), .bit_out(bit_out_b), .bit_active(bit_active_b),
    .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: alternating preamble, sync MSB-first, payload MSB-first, then a
  // byte-wise CRC-8 (poly 0x07) over the payload.
  function automatic bitq_t frame_model(input logic [71:0] d, input int pre, input bit crc_en);
    bitq_t      q;
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 0; i < pre; i++) q.push_back(bit'((i % 2) == 0));
    for (int i = 7; i >= 0; i--) q.push_back(SYNC_W[i]);
    for (int i = 71; i >= 0; i--) q.push_back(d[i]);
    if (crc_en) begin
      for (int j = 8; j >= 0; j--) begin
        crc = crc ^ d[j*8 +: 8];
        for (int k = 0; k < 8; k++) crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
      end
      for (int i = 7; i >= 0; i--) q.push_back(crc[i]);
    end
    return q;
  endfunction

  task automatic start_a(input logic [71:0] d);
    chk("a_ready_before_hs", pkt_ready_a, 1'b1);
    pkt_data    = d;
    pkt_valid_a = 1'b1;
    tick();
    pkt_valid_a = 1'b0;
    chk("a_after_hs", {pkt_ready_a, bit_active_a, frame_done_a}, 3'b010);
    exp_a = frame_model(d, 4, 1'b1);
    pos_a = 0;
  endtask

  task automatic stream_a(input int gap, input int n);
    for (int k = 0; k < n; k++) begin
      chk("a_bit", {bit_active_a, bit_out_a, frame_done_a, pkt_ready_a}, {1'b1, exp_a[pos_a], 2'b00});
      cap_a      = {cap_a[6:0], bit_out_a};
      bit_next_a = 1'b1;
      tick();
      bit_next_a = 1'b0;
      pos_a++;
      if (pos_a == exp_a.size()) begin
        chk("a_end", {frame_done_a, bit_active_a, bit_out_a, pkt_ready_a}, 4'b1001);
        break;
      end
      for (int g = 1; g < gap; g++) begin
        chk("a_hold", {bit_active_a, bit_out_a, frame_done_a, pkt_ready_a}, {1'b1, exp_a[pos_a], 2'b00});
        tick();
      end
    end
  endtask

  task automatic finish_idle_a();
    tick();
    chk("a_done_one_cycle", {frame_done_a, bit_active_a, bit_out_a, pkt_ready_a}, 4'b0001);
  endtask

  task automatic run_b(input logic [71:0] d);
    exp_b = frame_model(d, 0, 1'b0);
    chk("b_ready_before_hs", pkt_ready_b, 1'b1);
    pkt_data    = d;
    pkt_valid_b = 1'b1;
    bit_next_b  = 1'b1;
    tick();
    pkt_valid_b = 1'b0;
    for (int i = 0; i < exp_b.size(); i++) begin
      chk("b_bit", {bit_active_b, bit_out_b, frame_done_b, pkt_ready_b}, {1'b1, exp_b[i], 2'b00});
      tick();
    end
    chk("b_end", {frame_done_b, bit_active_b, bit_out_b, pkt_ready_b}, 4'b1001);
    bit_next_b = 1'b0;
    tick();
    chk("b_done_one_cycle", {frame_done_b, bit_active_b, bit_out_b, pkt_ready_b}, 4'b0001);
  endtask

  initial begin
    logic [95:0] r;
    logic [71:0] d1;

    #3;
    chk("reset_outputs", {pkt_ready_a, bit_out_a, bit_active_a, frame_done_a,
                          pkt_ready_b, bit_out_b, bit_active_b, frame_done_b}, 8'h00);
    tick();
    tick();
    rstn = 1'b1;
    chk("ready_low_before_edge", {pkt_ready_a, pkt_ready_b}, 2'b00);
    tick();
    chk("ready_after_release", {pkt_ready_a, pkt_ready_b}, 2'b11);

    // Directed "123456789" frame, bit_next every 4 cycles.
    start_a(MSG);
    stream_a(4, 92);
    chk("a_crc_f4", cap_a, 8'hF4);
    finish_idle_a();

    repeat (3) begin
      r = {$urandom, $urandom, $urandom};
      start_a(r[71:0]);
      stream_a(int'($urandom_range(1, 4)), 92);
      finish_idle_a();
    end

    // Second packet held valid during the frame is taken only at L+1.
    r  = {$urandom, $urandom, $urandom};
    d1 = r[71:0];
    start_a(d1);
    pkt_data    = MSG;
    pkt_valid_a = 1'b1;
    stream_a(3, 92);
    tick();
    chk("bp_hs_at_l_plus_1", {pkt_ready_a, bit_active_a, frame_done_a, bit_out_a}, 4'b0101);
    pkt_valid_a = 1'b0;
    exp_a = frame_model(MSG, 4, 1'b1);
    pos_a = 0;
    stream_a(2, 92);
    chk("bp_crc_f4", cap_a, 8'hF4);
    finish_idle_a();

    // Clear mid-payload together with bit_next.
    r = {$urandom, $urandom, $urandom};
    start_a(r[71:0]);
    stream_a(2, 20);
    clear_a    = 1'b1;
    bit_next_a = 1'b1;
    tick();
    clear_a    = 1'b0;
    bit_next_a = 1'b0;
    chk("clear_idle", {frame_done_a, bit_active_a, bit_out_a, pkt_ready_a}, 4'b0001);
    tick();
    chk("clear_no_done", {frame_done_a, bit_active_a, bit_out_a, pkt_ready_a}, 4'b0001);
    clear_a     = 1'b1;
    pkt_valid_a = 1'b1;
    pkt_data    = MSG;
    tick();
    clear_a     = 1'b0;
    pkt_valid_a = 1'b0;
    chk("clear_blocks_hs", {pkt_ready_a, bit_active_a, frame_done_a}, 3'b100);
    start_a(MSG);
    stream_a(1, 92);
    chk("clear_crc_f4", cap_a, 8'hF4);
    finish_idle_a();

    // Zero preamble, no CRC, continuous advance.
    run_b(MSG);
    repeat (2) begin
      r = {$urandom, $urandom, $urandom};
      run_b(r[71:0]);
    end

    // Asynchronous reset mid-frame.
    start_a(MSG);
    stream_a(1, 30);
    rstn = 1'b0;
    #2;
    chk("async_reset_outputs", {pkt_ready_a, bit_out_a, bit_active_a, frame_done_a,
                                pkt_ready_b, bit_out_b, bit_active_b, frame_done_b}, 8'h00);
    tick();
    rstn = 1'b1;
    chk("ready_low_after_rerelease", pkt_ready_a, 1'b0);
    tick();
    chk("ready_after_rerelease", {pkt_ready_a, pkt_ready_b}, 2'b11);
    start_a(MSG);
    stream_a(1, 92);
    chk("post_reset_crc_f4", cap_a, 8'hF4);
    finish_idle_a();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
